// File: rtl/relogio_pkg.sv
// Shared types and BCD helpers for the clock set-time path.
package relogio_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t msd;
    bcd_t lsd;
  } bcd_pair_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } set_state_t;

  localparam bcd_pair_t HOUR_MAX = 8'h23;
  localparam bcd_pair_t MIN_MAX  = 8'h59;

  // Increment a two-digit BCD value, carrying x9 into the msd and wrapping max to 00.
  function automatic bcd_pair_t bcd_inc_wrap(input bcd_pair_t value, input bcd_pair_t max);
    bcd_pair_t r;
    if (value == max) begin
      r = '0;
    end else if (value.lsd == 4'd9) begin
      r.msd = value.msd + 4'd1;
      r.lsd = 4'd0;
    end else begin
      r.msd = value.msd;
      r.lsd = value.lsd + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stable-count debounce, press pulse on high->low.
module key_debouncer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // The level only follows the synchronised key after CYCLES consecutive differing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      press  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_b;
        press <= ~sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Set-time sequencer: mode/inc buttons edit a captured HH:MM and emit a one-cycle load.
// Optional inc auto-repeat is built when TIME_SET_AUTOREPEAT_EN is defined.
module time_set_ctrl
  import relogio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_TICKS   = 10,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       tick_1hz,
  input  logic [7:0] cur_h,
  input  logic [7:0] cur_m,
  output logic [7:0] set_h,
  output logic [7:0] set_m,
  output logic       load,
  output logic       editing,
  output logic       blink_h,
  output logic       blink_m
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  logic mode_level, mode_press;
  logic inc_level, inc_press;
  logic inc_ev;

  key_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clock (clock),
    .reset (reset),
    .key_n (key_mode_n),
    .level (mode_level),
    .press (mode_press)
  );

  key_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clock (clock),
    .reset (reset),
    .key_n (key_inc_n),
    .level (inc_level),
    .press (inc_press)
  );

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic          rpt_pulse;
  logic          unused_levels;

  assign unused_levels = mode_level;

  // While inc stays held, the first repeat waits the long delay, later ones the short period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_pulse <= 1'b0;
    end else begin
      rpt_pulse <= 1'b0;
      if (inc_level) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
        rpt_pulse <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign inc_ev = inc_press | rpt_pulse;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_levels;

  assign unused_levels = mode_level ^ inc_level;
  assign inc_ev        = inc_press;
`endif

  set_state_t    state;
  logic          phase;
  logic [TW-1:0] tmo;

  // A mode press always wins over a simultaneous inc; any press restarts the timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      set_h   <= '0;
      set_m   <= '0;
      load    <= 1'b0;
      editing <= 1'b0;
      blink_h <= 1'b0;
      blink_m <= 1'b0;
      phase   <= 1'b0;
      tmo     <= '0;
    end else begin
      load <= 1'b0;
      unique case (state)
        RUN: begin
          phase   <= 1'b0;
          blink_h <= 1'b0;
          blink_m <= 1'b0;
          tmo     <= '0;
          if (mode_press) begin
            state   <= SET_HOUR;
            set_h   <= cur_h;
            set_m   <= cur_m;
            editing <= 1'b1;
          end
        end
        SET_HOUR, SET_MIN: begin
          if (mode_press) begin
            state   <= (state == SET_HOUR) ? SET_MIN : COMMIT;
            editing <= (state == SET_HOUR);
            load    <= (state == SET_MIN);
            phase   <= 1'b0;
            blink_h <= 1'b0;
            blink_m <= 1'b0;
            tmo     <= '0;
          end else if (tick_1hz && !inc_ev && tmo == TMO_LAST) begin
            state   <= RUN;
            editing <= 1'b0;
            phase   <= 1'b0;
            blink_h <= 1'b0;
            blink_m <= 1'b0;
            tmo     <= '0;
          end else begin
            if (inc_ev) begin
              tmo <= '0;
              if (state == SET_HOUR) set_h <= bcd_inc_wrap(set_h, HOUR_MAX);
              else                   set_m <= bcd_inc_wrap(set_m, MIN_MAX);
            end else if (tick_1hz) begin
              tmo <= tmo + 1'b1;
            end
            if (tick_1hz) begin
              phase <= ~phase;
              if (state == SET_HOUR) blink_h <= ~phase;
              else                   blink_m <= ~phase;
            end
          end
        end
        COMMIT: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl with short debounce/repeat/timeout parameters.
module tb_time_set_ctrl;

  logic       clock;
  logic       reset;
  logic       key_mode_n;
  logic       key_inc_n;
  logic       tick_1hz;
  logic [7:0] cur_h;
  logic [7:0] cur_m;
  logic [7:0] set_h;
  logic [7:0] set_m;
  logic       load;
  logic       editing;
  logic       blink_h;
  logic       blink_m;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_TICKS   (10),
    .REPEAT_DELAY    (40),
    .REPEAT_PERIOD   (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_mode_n (key_mode_n),
    .key_inc_n  (key_inc_n),
    .tick_1hz   (tick_1hz),
    .cur_h      (cur_h),
    .cur_m      (cur_m),
    .set_h      (set_h),
    .set_m      (set_m),
    .load       (load),
    .editing    (editing),
    .blink_h    (blink_h),
    .blink_m    (blink_m)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    bit         is_load;
    logic [7:0] h;
    logic [7:0] m;
    logic       ed;
    logic       bh;
    logic       bm;
    logic       ld;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  logic snap_req = 1'b0;

  // Monitor: a load pulse consumes a load expectation, a snapshot request consumes a snapshot one.
  always @(negedge clock) begin
    if (load === 1'b1) begin
      checks++;
      if (exp_q.size() == 0 || !exp_q[0].is_load) begin
        failures++;
        $display("[TB] FAIL unexpected_load got load=1 set=%h:%h required load=0", set_h, set_m);
      end else begin
        mon_e = exp_q.pop_front();
        if ({set_h, set_m} !== {mon_e.h, mon_e.m}) begin
          failures++;
          $display("[TB] FAIL %s got set=%h:%h required set=%h:%h", mon_e.name, set_h, set_m, mon_e.h, mon_e.m);
        end
      end
    end
    if (snap_req) begin
      while (exp_q.size() != 0 && exp_q[0].is_load) begin
        mon_e = exp_q.pop_front();
        checks++;
        failures++;
        $display("[TB] FAIL %s got no load pulse required load pulse with %h:%h", mon_e.name, mon_e.h, mon_e.m);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL snapshot_without_expectation got request required queued expectation");
      end else begin
        mon_e = exp_q.pop_front();
        if ({set_h, set_m, editing, blink_h, blink_m, load} !==
            {mon_e.h, mon_e.m, mon_e.ed, mon_e.bh, mon_e.bm, mon_e.ld}) begin
          failures++;
          $display("[TB] FAIL %s got h=%h m=%h ed=%b bh=%b bm=%b ld=%b required h=%h m=%h ed=%b bh=%b bm=%b ld=%b",
                   mon_e.name, set_h, set_m, editing, blink_h, blink_m, load,
                   mon_e.h, mon_e.m, mon_e.ed, mon_e.bh, mon_e.bm, mon_e.ld);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [7:0] h, input logic [7:0] m,
                              input logic ed, input logic bh, input logic bm, input logic ld);
    exp_t e;
    e.name = name; e.is_load = 1'b0; e.h = h; e.m = m;
    e.ed = ed; e.bh = bh; e.bm = bm; e.ld = ld;
    exp_q.push_back(e);
    @(posedge clock);
    snap_req = 1'b1;
    @(posedge clock);
    snap_req = 1'b0;
  endtask

  task automatic expect_load(input string name, input logic [7:0] h, input logic [7:0] m);
    exp_t e;
    e.name = name; e.is_load = 1'b1; e.h = h; e.m = m;
    e.ed = 1'b0; e.bh = 1'b0; e.bm = 1'b0; e.ld = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit use_mode, input bit use_inc, input int hold);
    @(negedge clock);
    if (use_mode) key_mode_n = 1'b0;
    if (use_inc)  key_inc_n  = 1'b0;
    repeat (hold) @(negedge clock);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic pulse_tick();
    @(negedge clock);
    tick_1hz = 1'b1;
    @(negedge clock);
    tick_1hz = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; key_mode_n = 1'b1; key_inc_n = 1'b1; tick_1hz = 1'b0;
    cur_h = 8'h00; cur_m = 8'h00;
    repeat (3) @(negedge clock);
    check_output("reset_init", 8'h00, 8'h00, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;

    // Reset in the middle of an edit
    cur_h = 8'h13; cur_m = 8'h45;
    apply_stimulus(1, 0, 8);
    check_output("edit_entry_pre_reset", 8'h13, 8'h45, 1, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    check_output("reset_mid_edit", 8'h00, 8'h00, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_output("idle_after_reset", 8'h00, 8'h00, 0, 0, 0, 0);

    // Full edit with hour and minute wrap; cur_* changes mid-edit are ignored
    apply_stimulus(1, 0, 8);
    check_output("capture_13_45", 8'h13, 8'h45, 1, 0, 0, 0);
    cur_h = 8'h22; cur_m = 8'h11;
    repeat (10) apply_stimulus(0, 1, 8);
    check_output("hour_reaches_23", 8'h23, 8'h45, 1, 0, 0, 0);
    apply_stimulus(0, 1, 8);
    check_output("hour_wraps_00", 8'h00, 8'h45, 1, 0, 0, 0);
    apply_stimulus(1, 0, 8);
    check_output("enter_set_min", 8'h00, 8'h45, 1, 0, 0, 0);
    repeat (14) apply_stimulus(0, 1, 8);
    check_output("min_reaches_59", 8'h00, 8'h59, 1, 0, 0, 0);
    apply_stimulus(0, 1, 8);
    check_output("min_wraps_00", 8'h00, 8'h00, 1, 0, 0, 0);
    expect_load("load_00_00", 8'h00, 8'h00);
    apply_stimulus(1, 0, 8);
    check_output("after_commit_00_00", 8'h00, 8'h00, 0, 0, 0, 0);

    // Bounce rejection, single step on hold, simultaneous mode+inc
    cur_h = 8'h08; cur_m = 8'h29;
    apply_stimulus(1, 0, 8);
    check_output("capture_08_29", 8'h08, 8'h29, 1, 0, 0, 0);
    apply_stimulus(0, 1, 3);
    check_output("glitch_ignored", 8'h08, 8'h29, 1, 0, 0, 0);
    apply_stimulus(0, 1, 8);
    check_output("held_inc_once", 8'h09, 8'h29, 1, 0, 0, 0);
    apply_stimulus(1, 0, 8);
    check_output("set_min_at_29", 8'h09, 8'h29, 1, 0, 0, 0);
    expect_load("load_mode_inc_same_cycle", 8'h09, 8'h29);
    apply_stimulus(1, 1, 8);
    check_output("after_commit_09_29", 8'h09, 8'h29, 0, 0, 0, 0);

    // Timeout in SET_HOUR with blink toggling
    cur_h = 8'h17; cur_m = 8'h05;
    apply_stimulus(1, 0, 8);
    check_output("capture_17_05", 8'h17, 8'h05, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      pulse_tick();
      check_output($sformatf("blink_tick_%0d", k), 8'h17, 8'h05, 1, logic'(k % 2), 0, 0);
    end
    pulse_tick();
    check_output("timeout_to_run", 8'h17, 8'h05, 0, 0, 0, 0);

    // Long inc hold in SET_MIN
    cur_h = 8'h12; cur_m = 8'h00;
    apply_stimulus(1, 0, 8);
    apply_stimulus(1, 0, 8);
    check_output("set_min_at_00", 8'h12, 8'h00, 1, 0, 0, 0);
    apply_stimulus(0, 1, 70);
`ifdef TIME_SET_AUTOREPEAT_EN
    check_output("long_hold_repeat", 8'h12, 8'h04, 1, 0, 0, 0);
    expect_load("load_after_repeat", 8'h12, 8'h04);
`else
    check_output("long_hold_single", 8'h12, 8'h01, 1, 0, 0, 0);
    expect_load("load_after_hold", 8'h12, 8'h01);
`endif
    apply_stimulus(1, 0, 8);
    check_output("final_idle", 8'h12, set_m_final(), 0, 0, 0, 0);

    repeat (5) @(negedge clock);
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s got nothing required pending expectation consumed", mon_e.name);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [7:0] set_m_final();
`ifdef TIME_SET_AUTOREPEAT_EN
    return 8'h04;
`else
    return 8'h01;
`endif
  endfunction

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog got timeout required completion within 20000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
